lif_neuron: RTL and testbench

- Leaky integrate-and-fire postsynaptic neuron; the stage directly upstream of the STDP timing/weight block.
- Accumulates the weights of the 4 synapses whose presynaptic spikes are active into a leaky membrane potential.
- When the potential crosses threshold, emits a 1-cycle post_spike pulse, then holds off for a refractory period.
- Consumes the packed 16-bit weight bus produced by the STDP block; its post_spike drives the STDP block's post_spike input.

---
 rtl/lif_neuron_if.sv | 36 +++
 rtl/lif_neuron.sv | 158 +++++++++++++++
 tb/tb_lif_neuron.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lif_neuron_if.sv
// lif_neuron_if: time-step enable, presynaptic spike/weight inputs and the
// neuron's observable outputs, bundled for the leaky integrate-and-fire neuron.
//   en          - time-step enable (low freezes the neuron)
//   pre_spike   - NUM_PRE presynaptic spikes
//   weight      - packed weights; synapse 0 occupies the most-significant nibble
//   post_spike  - 1-cycle fire pulse
//   membrane    - membrane potential
//   refractory  - high while the neuron is refractory
//   spike_count - saturating fire counter (only with LIF_SPIKE_COUNT_EN)
// master: the side driving stimulus (upstream STDP / bench).
// slave : the neuron itself.
interface lif_neuron_if #(
  parameter int NUM_PRE = 4,
  parameter int W_WIDTH = 4,
  parameter int V_WIDTH = 8
);
  logic                       en;
  logic [NUM_PRE-1:0]         pre_spike;
  logic [NUM_PRE*W_WIDTH-1:0] weight;
  logic                       post_spike;
  logic [V_WIDTH-1:0]         membrane;
  logic                       refractory;
`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0]                 spike_count;

  modport master (output en, pre_spike, weight,
                  input  post_spike, membrane, refractory, spike_count);
  modport slave  (input  en, pre_spike, weight,
                  output post_spike, membrane, refractory, spike_count);
`else
  modport master (output en, pre_spike, weight,
                  input  post_spike, membrane, refractory);
  modport slave  (input  en, pre_spike, weight,
                  output post_spike, membrane, refractory);
`endif
endinterface

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire postsynaptic neuron.
// Each enabled edge in INTEGRATE adds the weights of the active synapses to a
// leaky membrane potential (leak = v >> LEAK_SHIFT, saturating at the top).
// Crossing THRESHOLD emits a registered 1-cycle post_spike, clears the
// membrane and enters REFRACTORY for REFRACT_CYCLES enabled cycles.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   nrn  - lif_neuron_if slave modport (en, pre_spike, weight in;
//          post_spike, membrane, refractory[, spike_count] out)
// Optional feature: define LIF_SPIKE_COUNT_EN to add an 8-bit saturating
// spike_count output incremented once per fire.
module lif_neuron #(
  parameter int NUM_PRE        = 4,
  parameter int W_WIDTH        = 4,
  parameter int V_WIDTH        = 8,
  parameter int THRESHOLD      = 32,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 4
) (
  input logic         clk,
  input logic         rst,
  lif_neuron_if.slave nrn
);

  localparam int SUM_W = V_WIDTH + 2;
  localparam int CNT_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [V_WIDTH-1:0] V_MAX = '1;

  typedef enum logic [0:0] {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } state_t;

  state_t             state_r, state_nx;
  logic [V_WIDTH-1:0] membrane_r, membrane_nx;
  logic [CNT_W-1:0]   cnt_r, cnt_nx;
  logic               refr_r, refr_nx;
  logic               post_r, post_nx;
  logic [SUM_W-1:0]   sum_s;
  logic [SUM_W-1:0]   v_raw_s;
  logic [V_WIDTH-1:0] v_next_s;
  logic               fire_s;

  // Sum of weights on active synapses; synapse 0 sits in the top nibble.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (nrn.pre_spike[i]) begin
        sum_s = sum_s + SUM_W'(nrn.weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
      end else begin
        sum_s = sum_s;
      end
    end
  end

  // Leak, integrate and saturate; the wide intermediate cannot underflow
  // because the leak term is never larger than the membrane itself.
  always_comb begin
    v_raw_s = SUM_W'(membrane_r) - SUM_W'(membrane_r >> LEAK_SHIFT) + sum_s;
    if (v_raw_s > SUM_W'(V_MAX)) begin
      v_next_s = V_MAX;
    end else begin
      v_next_s = v_raw_s[V_WIDTH-1:0];
    end
    fire_s = (SUM_W'(v_next_s) >= SUM_W'(THRESHOLD));
  end

  // Next-state and next-output logic for the INTEGRATE/REFRACTORY FSM.
  always_comb begin
    state_nx    = state_r;
    membrane_nx = membrane_r;
    cnt_nx      = cnt_r;
    refr_nx     = refr_r;
    post_nx     = 1'b0;
    if (nrn.en) begin
      case (state_r)
        ST_INTEGRATE: begin
          if (fire_s) begin
            membrane_nx = '0;
            post_nx     = 1'b1;
            // A zero refractory period keeps integrating so back-to-back fires are possible.
            if (REFRACT_CYCLES == 0) begin
              state_nx = ST_INTEGRATE;
              refr_nx  = 1'b0;
              cnt_nx   = '0;
            end else begin
              state_nx = ST_REFRACTORY;
              refr_nx  = 1'b1;
              cnt_nx   = CNT_W'(REFRACT_CYCLES);
            end
          end else begin
            membrane_nx = v_next_s;
          end
        end
        ST_REFRACTORY: begin
          membrane_nx = '0;
          // Leaving on the edge that takes the counter to zero keeps refractory
          // high for exactly REFRACT_CYCLES enabled cycles.
          if (cnt_r <= CNT_W'(1)) begin
            cnt_nx   = '0;
            state_nx = ST_INTEGRATE;
            refr_nx  = 1'b0;
          end else begin
            cnt_nx = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_nx    = ST_INTEGRATE;
          membrane_nx = '0;
          cnt_nx      = '0;
          refr_nx     = 1'b0;
        end
      endcase
    end else begin
      post_nx = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_INTEGRATE;
      membrane_r <= '0;
      cnt_r      <= '0;
      refr_r     <= 1'b0;
      post_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      membrane_r <= membrane_nx;
      cnt_r      <= cnt_nx;
      refr_r     <= refr_nx;
      post_r     <= post_nx;
    end
  end

  assign nrn.post_spike = post_r;
  assign nrn.membrane   = membrane_r;
  assign nrn.refractory = refr_r;

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] spike_count_r;

  // Counts fires alongside the post_spike register, sticking at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_count_r <= 8'd0;
    end else if (post_nx && (spike_count_r != 8'd255)) begin
      spike_count_r <= spike_count_r + 8'd1;
    end else begin
      spike_count_r <= spike_count_r;
    end
  end

  assign nrn.spike_count = spike_count_r;
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: self-checking bench for lif_neuron. A behavioural model
// tracks the membrane as an integer and the refractory period as a count of
// remaining cycles; directed sequences plus randomized stimulus are compared
// against it every cycle, with a few spec-derived constant sequences as well.
module tb_lif_neuron;
  localparam int NUM_PRE        = 4;
  localparam int W_WIDTH        = 4;
  localparam int V_WIDTH        = 8;
  localparam int THRESHOLD      = 32;
  localparam int LEAK_SHIFT     = 3;
  localparam int REFRACT_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;

  lif_neuron_if #(.NUM_PRE(NUM_PRE), .W_WIDTH(W_WIDTH), .V_WIDTH(V_WIDTH)) nrn ();

  lif_neuron #(
    .NUM_PRE(NUM_PRE), .W_WIDTH(W_WIDTH), .V_WIDTH(V_WIDTH),
    .THRESHOLD(THRESHOLD), .LEAK_SHIFT(LEAK_SHIFT), .REFRACT_CYCLES(REFRACT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .nrn(nrn.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_v;
  int m_left;
  int m_post;
  int m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_left = 0; m_post = 0; m_cnt = 0;
  endtask

  // One clock edge of the neuron, evaluated from the current inputs.
  task automatic model_edge();
    int sum;
    int vn;
    logic [15:0] wv;
    if (nrn.en !== 1'b1) begin
      m_post = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_v    = 0;
      m_post = 0;
    end else begin
      wv  = nrn.weight;
      sum = 0;
      for (int i = 0; i < NUM_PRE; i++) begin
        if (nrn.pre_spike[i]) sum += int'(wv >> ((NUM_PRE - 1 - i) * W_WIDTH)) % 16;
      end
      vn = m_v - m_v / (1 << LEAK_SHIFT) + sum;
      if (vn > 255) vn = 255;
      if (vn >= THRESHOLD) begin
        m_v    = 0;
        m_post = 1;
        m_left = REFRACT_CYCLES;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_v    = vn;
        m_post = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".membrane"}, 32'(nrn.membrane), 32'(m_v));
    check_eq({tag, ".post_spike"}, 32'(nrn.post_spike), 32'(m_post));
    check_eq({tag, ".refractory"}, 32'(nrn.refractory), 32'(m_left > 0));
`ifdef LIF_SPIKE_COUNT_EN
    check_eq({tag, ".spike_count"}, 32'(nrn.spike_count), 32'(m_cnt));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    rst = 1'b0;
  endtask

  int leak_exp [15] = '{25, 22, 20, 18, 16, 14, 13, 12, 11, 10, 9, 8, 7, 7, 7};
  int ramp_exp [4]  = '{8, 15, 22, 28};

  initial begin
    rst           = 1'b1;
    nrn.en        = 1'b0;
    nrn.pre_spike = 4'b0000;
    nrn.weight    = 16'h0000;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Full drive: fire, 4 refractory cycles, fire again.
    nrn.en = 1'b1; nrn.weight = 16'hFFFF; nrn.pre_spike = 4'b1111;
    for (int i = 0; i < 12; i++) step("full");

    // Async reset in the middle of refractory.
    step("full2");
    step("full3");
    check_eq("pre_rst_refractory", 32'(nrn.refractory), 32'd1);
    async_reset("rst_mid_refr");
    step("after_rst");
    check_eq("after_rst_fires", 32'(nrn.post_spike), 32'd1);

    // Leaky ramp from zero.
    @(negedge clk);
    rst = 1'b1; model_reset();
    @(negedge clk);
    rst = 1'b0;
    nrn.weight = 16'h8000; nrn.pre_spike = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step("ramp");
      check_eq("ramp_const", 32'(nrn.membrane), 32'(ramp_exp[i]));
    end
    step("ramp_fire");
    check_eq("ramp_fire_pulse", 32'(nrn.post_spike), 32'd1);
    step("ramp_after");
    check_eq("ramp_pulse_width", 32'(nrn.post_spike), 32'd0);

    // Pure leak from 28.
    @(negedge clk);
    rst = 1'b1; model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step("leak_ramp");
    nrn.pre_spike = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      step("leak");
      check_eq("leak_const", 32'(nrn.membrane), 32'(leak_exp[i]));
      check_eq("leak_nospike", 32'(nrn.post_spike), 32'd0);
    end

    // Enable gating mid-ramp and mid-refractory.
    @(negedge clk);
    rst = 1'b1; model_reset();
    @(negedge clk);
    rst = 1'b0;
    nrn.pre_spike = 4'b0001;
    step("gate_a"); step("gate_b");
    nrn.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("gate_off_ramp");
      check_eq("gate_hold_ramp", 32'(nrn.membrane), 32'd15);
    end
    nrn.en = 1'b1;
    for (int i = 0; i < 4; i++) step("gate_resume");
    nrn.en = 1'b0;
    for (int i = 0; i < 3; i++) step("gate_off_refr");
    nrn.en = 1'b1;
    for (int i = 0; i < 6; i++) step("gate_resume2");

    // Randomized stimulus with occasional enable drops and async resets.
    for (int i = 0; i < 600; i++) begin
      nrn.en        = ($urandom_range(0, 9) != 0);
      nrn.pre_spike = 4'($urandom);
      nrn.weight    = 16'($urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h3333));
      if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
      else step("rand");
    end

`ifdef LIF_SPIKE_COUNT_EN
    // Long full drive saturates the spike counter.
    nrn.en = 1'b1; nrn.weight = 16'hFFFF; nrn.pre_spike = 4'b1111;
    for (int i = 0; i < 2000; i++) step("count");
    check_eq("count_saturated", 32'(nrn.spike_count), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
